mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit that produces the HI/LO results for the multicycle CPU's mult/div instruction class. It replaces the separate fixed-width multiplier, divider and HI/LO-select path with a single engine. The engine has a start/done handshake, internal HI/LO registers and divide-by-zero detection. The control unit issues a start, stalls on busy, and reads HI/LO through the register-writeback mux once done pulses.

---
 rtl/mult_div_unit_if.sv | 31 +++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the CPU control unit and the mult/div engine.
// Latency: none (wires only).
// Backpressure: the control unit stalls on busy; start is ignored while busy is high.
//
// Ports:
//   start, op_div, unsigned_op, a, b : issued by the control unit (master)
//   busy, done, div0, hi, lo          : returned by the engine (slave)
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             unsigned_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_div, unsigned_op, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op_div, unsigned_op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO for mult/div instructions.
// Latency: WIDTH+1 cycles from the start edge to done (1 cycle when dividing by zero).
// Backpressure: busy is high outside IDLE; a start seen while busy is dropped, not queued.
//
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus.slave  : start/op_div/unsigned_op/a/b in; busy/done/div0/hi/lo out
// Optional feature: define MULTDIV_UNSIGNED_EN to honour unsigned_op (multu/divu);
// otherwise every operation is signed and unsigned_op is ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;    // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] dsr;       // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_main;  // negate product or quotient
    logic             neg_rem;   // negate remainder (follows dividend sign)
    logic             zero_div;
    logic             done_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             start_ok;
    logic             div_by_zero_req;
    logic             sgn_mode;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef MULTDIV_UNSIGNED_EN
    assign sgn_mode = !bus.unsigned_op;
`else
    // Constant signed mode lets synthesis drop the unsigned bypass entirely.
    logic unused_unsigned_op;
    assign unused_unsigned_op = bus.unsigned_op;
    assign sgn_mode = 1'b1;
`endif

    assign start_ok        = (state == IDLE) && bus.start;
    assign div_by_zero_req = bus.op_div && (bus.b == '0);
    assign sa              = sgn_mode && bus.a[WIDTH-1];
    assign sb              = sgn_mode && bus.b[WIDTH-1];
    // The most-negative value maps to itself, which is the correct unsigned magnitude.
    assign mag_a           = sa ? -bus.a : bus.a;
    assign mag_b           = sb ? -bus.b : bus.b;

    // One iteration of each algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? dsr : {WIDTH{1'b0}})};
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dsr};
    assign prod      = {acc_hi, acc_lo};
    assign prod_neg  = -prod;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = div_by_zero_req ? FIX : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state != IDLE);
    end

    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            dsr      <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        is_div   <= bus.op_div;
                        neg_main <= sa ^ sb;
                        neg_rem  <= sa;
                        zero_div <= div_by_zero_req;
                        cnt      <= CW'(WIDTH - 1);
                        div0_q   <= 1'b0;
                        acc_hi   <= '0;
                        dsr      <= bus.op_div ? mag_b : mag_a;
                        acc_lo   <= bus.op_div ? mag_a : mag_b;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        // Restoring step: keep the subtraction only when it did not borrow.
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        // Add-then-shift-right of {carry, acc_hi, acc_lo}.
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (zero_div) begin
                        div0_q <= 1'b1;
                    end else if (is_div) begin
                        lo_q <= neg_main ? -acc_lo : acc_lo;
                        hi_q <= neg_rem  ? -acc_hi : acc_hi;
                    end else begin
                        {hi_q, lo_q} <= neg_main ? prod_neg : prod;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed bench for mult_div_unit against a plain-arithmetic reference model.
// Latency: checks done arrives WIDTH+1 cycles after the start edge (1 for divide by zero).
// Backpressure: checks that starts issued while busy are dropped.
module tb_mult_div_unit;
    localparam int W = 32;
`ifdef MULTDIV_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: HI/LO/div0 as the architecture should see them.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_div0 = 1'b0;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_op(input logic op, input logic uns,
                                     input logic [31:0] x, input logic [31:0] y);
        logic        sm;
        longint      sx, sy, r;
        logic [63:0] v;
        sm = !(uns && UNS_EN);
        sx = sm ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sm ? longint'($signed(y)) : longint'({32'b0, y});
        if (op && y == 32'd0) begin
            m_div0 = 1'b1;
        end else begin
            m_div0 = 1'b0;
            if (!op) begin
                r = sx * sy;
                v = r;
                m_hi = v[63:32];
                m_lo = v[31:0];
            end else begin
                r = sx / sy;
                v = r;
                m_lo = v[31:0];
                r = sx % sy;
                v = r;
                m_hi = v[31:0];
            end
        end
    endfunction

    task automatic start_op(input logic op, input logic uns,
                            input logic [31:0] x, input logic [31:0] y);
        bus.start       = 1'b1;
        bus.op_div      = op;
        bus.unsigned_op = uns;
        bus.a           = x;
        bus.b           = y;
        tick();
        bus.start       = 1'b0;
        bus.op_div      = 1'($urandom);
        bus.unsigned_op = 1'($urandom);
        bus.a           = $urandom;
        bus.b           = $urandom;
    endtask

    // Cycles from the start edge until done is seen; -1 if it never arrives.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.done && cyc < 100);
        if (!bus.done) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        checks++;
        if ({bus.done, bus.div0} !== 2'b00) begin
            errors++; $display("FAIL reset_done_div0: got %b expected 00", {bus.done, bus.div0});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
        end
    endtask

    task automatic test_mult_signed();
        int cyc;
        int extra_done;
        int extra_busy;
        start_op(1'b0, 1'b0, 32'd7, 32'hFFFFFFFD);
        model_op(1'b0, 1'b0, 32'd7, 32'hFFFFFFFD);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL mult_busy: got %b expected 1", bus.busy);
        end
        cyc = 1;
        // A start mid-operation (a divide by zero, which would be obvious if taken).
        while (!bus.done && cyc < 100) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op_div = 1'b1; bus.a = 32'd100; bus.b = 32'd0;
            end
            tick();
            bus.start = 1'b0;
            if (!bus.done) cyc++;
        end
        if (!bus.done) cyc = -1;
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL mult_latency: got %0d expected 33", cyc);
        end
        checks++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", bus.hi, bus.lo);
        end
        checks++;
        if (bus.div0 !== 1'b0) begin
            errors++; $display("FAIL mult_ignored_start_div0: got %b expected 0", bus.div0);
        end
        extra_done = 0;
        extra_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) extra_done++;
            if (bus.busy) extra_busy++;
        end
        checks++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            errors++; $display("FAIL mult_no_extra_op: got done=%0d busy=%0d expected 0 0", extra_done, extra_busy);
        end
    endtask

    task automatic test_div_back_to_back();
        int cyc;
        logic [31:0] x, y;
        start_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
        model_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc);
        checks++;
        if (cyc !== 33) begin
            errors++; $display("FAIL div_latency: got %0d expected 33", cyc);
        end
        checks++;
        if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF || bus.div0 !== 1'b0) begin
            errors++; $display("FAIL div_result: got lo=%h hi=%h div0=%b expected fffffffd ffffffff 0",
                               bus.lo, bus.hi, bus.div0);
        end
        // Issue in the done cycle.
        x = $urandom;
        y = $urandom;
        start_op(1'b0, 1'b0, x, y);
        model_op(1'b0, 1'b0, x, y);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got busy=%b expected 1", bus.busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 33 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            errors++; $display("FAIL b2b_result: got cyc=%0d %h_%h expected 33 %h_%h",
                               cyc, bus.hi, bus.lo, m_hi, m_lo);
        end
    endtask

    task automatic test_div0();
        int cyc;
        logic [31:0] ph, pl;
        start_op(1'b0, 1'b0, 32'h00123457, 32'h00ABCDEF);
        model_op(1'b0, 1'b0, 32'h00123457, 32'h00ABCDEF);
        wait_done(cyc);
        ph = m_hi;
        pl = m_lo;
        checks++;
        if (bus.hi !== ph || bus.lo !== pl) begin
            errors++; $display("FAIL div0_preload: got %h_%h expected %h_%h", bus.hi, bus.lo, ph, pl);
        end
        start_op(1'b1, 1'b0, 32'd5, 32'd0);
        model_op(1'b1, 1'b0, 32'd5, 32'd0);
        wait_done(cyc);
        checks++;
        if (cyc !== 1 || bus.div0 !== 1'b1) begin
            errors++; $display("FAIL div0_flag: got cyc=%0d div0=%b expected 1 1", cyc, bus.div0);
        end
        checks++;
        if (bus.hi !== ph || bus.lo !== pl) begin
            errors++; $display("FAIL div0_hilo_kept: got %h_%h expected %h_%h", bus.hi, bus.lo, ph, pl);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.div0 !== 1'b1) begin
            errors++; $display("FAIL div0_hold: got %b expected 1", bus.div0);
        end
        start_op(1'b0, 1'b0, 32'd3, 32'd4);
        model_op(1'b0, 1'b0, 32'd3, 32'd4);
        checks++;
        if (bus.div0 !== 1'b0) begin
            errors++; $display("FAIL div0_clear: got %b expected 0", bus.div0);
        end
        wait_done(cyc);
        checks++;
        if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
            errors++; $display("FAIL div0_next_op: got %h_%h expected 00000000_0000000c", bus.hi, bus.lo);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        start_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        model_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc);
        checks++;
        if (cyc !== 33 || bus.lo !== 32'h80000000 || bus.hi !== 32'h0 || bus.div0 !== 1'b0) begin
            errors++; $display("FAIL overflow: got cyc=%0d lo=%h hi=%h div0=%b expected 33 80000000 00000000 0",
                               cyc, bus.lo, bus.hi, bus.div0);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        start_op(1'b0, 1'b0, 32'h01234567, 32'h00089ABC);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0; m_div0 = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div0 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ctrl: got busy=%b done=%b div0=%b expected 0 0 0",
                               bus.busy, bus.done, bus.div0);
        end
        checks++;
        if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL reset_mid_hilo: got %h_%h expected 0_0", bus.hi, bus.lo);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", seen_done);
        end
    endtask

    task automatic test_unsigned();
        int cyc;
        logic [31:0] eh;
        eh = UNS_EN ? 32'hFFFFFFFE : 32'h00000000;
        start_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        model_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc);
        checks++;
        if (bus.hi !== eh || bus.lo !== 32'h00000001) begin
            errors++; $display("FAIL unsigned_mult: got %h_%h expected %h_00000001", bus.hi, bus.lo, eh);
        end
    endtask

    task automatic test_random();
        int cyc;
        int exp_cyc;
        logic op, uns;
        logic [31:0] x, y;
        for (int n = 0; n < 40; n++) begin
            op  = 1'($urandom);
            uns = 1'($urandom);
            x   = $urandom;
            y   = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                2: x = 32'h80000000;
                3: y = $urandom_range(1, 15);
                4: y = 32'h80000000;
                default: ;
            endcase
            start_op(op, uns, x, y);
            model_op(op, uns, x, y);
            exp_cyc = (op && y == 32'd0) ? 1 : 33;
            wait_done(cyc);
            checks++;
            if (cyc !== exp_cyc) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, cyc, exp_cyc);
            end
            checks++;
            if (bus.hi !== m_hi || bus.lo !== m_lo || bus.div0 !== m_div0) begin
                errors++; $display("FAIL rand_result[%0d] op=%b uns=%b a=%h b=%h: got %h_%h div0=%b expected %h_%h div0=%b",
                                   n, op, uns, x, y, bus.hi, bus.lo, bus.div0, m_hi, m_lo, m_div0);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.op_div      = 1'b0;
        bus.unsigned_op = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        #1;
        test_reset();
        test_mult_signed();
        test_div_back_to_back();
        test_div0();
        test_overflow();
        test_reset_mid();
        test_unsigned();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
